// File: rtl/io_out_fifo.sv
// rtl/io_out_fifo.sv - cpu output-port FIFO with first-word fall-through and sticky overflow
module io_out_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clr_ovf,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count_q;
    logic              ovf_q;
    logic              pop;
    logic              push;

    // Status and head word come only from registered state, never from wr_en.
    assign full      = (count_q == FULL_COUNT);
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? mem[rd_ptr] : '0;

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign pop  = out_valid & out_ready;
    assign push = wr_en & (~full | pop);

    // Storage is not cleared on reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers roll over naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy moves only when exactly one of push/pop happens.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Sticky drop flag; a new drop outranks a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr_en && full && !pop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_io_out_fifo.sv
// tb/tb_io_out_fifo.sv - randomized scoreboard bench for io_out_fifo
module tb_io_out_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       clr_ovf;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready;

    int checks = 0;
    int errors = 0;

    logic [7:0] q[$];
    logic [7:0] drained[$];
    bit         m_ovf = 0;
    bit         seen_reset = 0;

    io_out_fifo #(.DATA_W(8), .DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
        .clr_ovf(clr_ovf), .full(full), .count(count), .overflow(overflow),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #30 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of words plus the sticky flag.
    always @(posedge clk) begin
        bit mpop, mpush, mfull;
        if (reset) begin
            q.delete();
            m_ovf = 0;
            seen_reset = 1;
        end else if (seen_reset) begin
            mfull = (q.size() == 4);
            mpop  = (q.size() != 0) && out_ready;
            mpush = wr_en && (!mfull || mpop);
            if (mpop) drained.push_back(q.pop_front());
            if (mpush) q.push_back(wr_data);
            if (wr_en && mfull && !mpop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
        end
    end

    // Every cycle after the first reset, compare DUT outputs with the model.
    always @(negedge clk) begin
        if (seen_reset) begin
            chk("count", int'(count), q.size());
            chk("full", int'(full), int'(q.size() == 4));
            chk("out_valid", int'(out_valid), int'(q.size() != 0));
            chk("out_data", int'(out_data), (q.size() != 0) ? int'(q[0]) : 0);
            chk("overflow", int'(overflow), int'(m_ovf));
        end
    end

    task automatic drive(input bit r, input bit w, input logic [7:0] d, input bit c, input bit rdy);
        reset = r; wr_en = w; wr_data = d; clr_ovf = c; out_ready = rdy;
        @(negedge clk);
        #1;
    endtask

    initial begin
        reset = 1; wr_en = 0; wr_data = 0; clr_ovf = 0; out_ready = 0;

        // 1 reset
        drive(1, 0, 8'h00, 0, 0);
        chk("rst_count", int'(count), 0);
        chk("rst_full", int'(full), 0);
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_data", int'(out_data), 0);
        chk("rst_ovf", int'(overflow), 0);

        // 2 fill then overflow
        drive(0, 1, 8'h11, 0, 0);
        chk("ffwt_valid", int'(out_valid), 1);
        chk("ffwt_data", int'(out_data), 'h11);
        drive(0, 1, 8'h22, 0, 0);
        drive(0, 1, 8'h33, 0, 0);
        drive(0, 1, 8'h44, 0, 0);
        chk("fill_count", int'(count), 4);
        chk("fill_full", int'(full), 1);
        chk("fill_head", int'(out_data), 'h11);
        drive(0, 1, 8'h55, 0, 0);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_count", int'(count), 4);

        // 3 drain in order
        drained.delete();
        for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 0, 1);
        chk("drain_n", drained.size(), 4);
        if (drained.size() == 4) begin
            chk("drain0", int'(drained[0]), 'h11);
            chk("drain1", int'(drained[1]), 'h22);
            chk("drain2", int'(drained[2]), 'h33);
            chk("drain3", int'(drained[3]), 'h44);
        end
        chk("drain_count", int'(count), 0);
        chk("drain_valid", int'(out_valid), 0);
        chk("drain_data", int'(out_data), 0);

        // 4 full with simultaneous push and pop
        drive(0, 0, 8'h00, 1, 0);
        chk("ovf_clr", int'(overflow), 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'hA1 + 8'(i), 0, 0);
        drained.delete();
        drive(0, 1, 8'h66, 0, 1);
        chk("sim_count", int'(count), 4);
        chk("sim_ovf", int'(overflow), 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 8'h00, 0, 1);
        chk("sim_n", drained.size(), 5);
        if (drained.size() == 5) begin
            chk("sim_first", int'(drained[0]), 'hA1);
            chk("sim_last", int'(drained[4]), 'h66);
        end

        // 5 wrap: push/pop pairs with data 0..9
        drained.delete();
        for (int i = 0; i < 10; i++) drive(0, 1, 8'(i), 0, 1);
        drive(0, 0, 8'h00, 0, 1);
        chk("wrap_n", drained.size(), 10);
        for (int i = 0; i < 10 && i < drained.size(); i++)
            chk($sformatf("wrap%0d", i), int'(drained[i]), i);

        // 6 reset mid-drain, then set-beats-clear
        for (int i = 0; i < 3; i++) drive(0, 1, 8'hB0 + 8'(i), 0, 0);
        chk("pre_rst_count", int'(count), 3);
        drive(1, 1, 8'hEE, 0, 1);
        chk("mid_rst_count", int'(count), 0);
        chk("mid_rst_valid", int'(out_valid), 0);
        for (int i = 0; i < 4; i++) drive(0, 1, 8'hC0 + 8'(i), 0, 0);
        drive(0, 1, 8'hCF, 1, 0);
        chk("set_wins", int'(overflow), 1);
        drive(0, 0, 8'h00, 1, 0);
        chk("clr_only", int'(overflow), 0);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            drive(($urandom % 64) == 0, ($urandom % 3) != 0, 8'($urandom),
                  ($urandom % 8) == 0, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
